// File: rtl/hamming_secded_dec_pipe.sv
// Streaming SECDED Hamming decoder with a 2-stage pipeline and valid/ready on both sides; throughput is 1 word/cycle.
// Backpressure: in_ready drops once both stages are full. Defining HAMMING_DEC_ERRPOS_EN adds the out_err_pos port.
module hamming_secded_dec_pipe #(
    parameter int R     = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [(1<<R)-1:0]       in_code,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [(1<<R)-R-2:0]     out_data,
    output logic                    out_err,
    output logic                    out_uncorr,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        cnt_corr,
`ifdef HAMMING_DEC_ERRPOS_EN
    output logic [CNT_W-1:0]        cnt_uncorr,
    output logic [R-1:0]            out_err_pos
`else
    output logic [CNT_W-1:0]        cnt_uncorr
`endif
);

    localparam int N = 1 << R;
    localparam int K = N - R - 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Hamming position (1-based) of the j-th data bit: j-th non-power-of-two position.
    function automatic int data_pos(input int j);
        int cnt;
        cnt      = 0;
        data_pos = 0;
        for (int p = 1; p < N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) data_pos = p;
                cnt++;
            end
        end
    endfunction

    logic [R-1:0] syn_c;
    logic [K-1:0] raw_data;

    always_comb begin
        syn_c = '0;
        for (int i = 0; i < N - 1; i++) begin
            for (int k = 0; k < R; k++) begin
                if ((((i + 1) >> k) & 1) != 0) syn_c[k] = syn_c[k] ^ in_code[i];
            end
        end
    end

    for (genvar j = 0; j < K; j++) begin : g_ext
        assign raw_data[j] = in_code[data_pos(j) - 1];
    end

    logic         s1_valid;
    logic [K-1:0] s1_data;
    logic [R-1:0] s1_syn;
    logic         s1_par;
    logic         s2_load;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= raw_data;
                s1_syn  <= syn_c;
                s1_par  <= ^in_code;
            end
        end
    end

    logic         syn_nz;
    logic         single_c;
    logic [K-1:0] corr_data;

    assign syn_nz   = |s1_syn;
    assign single_c = syn_nz && s1_par;

    // A flipped parity-position bit carries no data, so only data positions need correcting.
    for (genvar j = 0; j < K; j++) begin : g_corr
        assign corr_data[j] = s1_data[j] ^ (single_c && (s1_syn == R'(data_pos(j))));
    end

`ifdef HAMMING_DEC_ERRPOS_EN
    logic [R-1:0] err_pos_c;

    always_comb begin
        err_pos_c = '0;
        if (single_c)              err_pos_c = s1_syn - {{(R-1){1'b0}}, 1'b1};
        else if (!syn_nz && s1_par) err_pos_c = '1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_err     <= 1'b0;
            out_uncorr  <= 1'b0;
`ifdef HAMMING_DEC_ERRPOS_EN
            out_err_pos <= '0;
`endif
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data    <= corr_data;
                out_err     <= syn_nz || s1_par;
                out_uncorr  <= syn_nz && !s1_par;
`ifdef HAMMING_DEC_ERRPOS_EN
                out_err_pos <= err_pos_c;
`endif
            end
        end
    end

    logic fire;
    assign fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (cnt_clr) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (fire) begin
            if (out_err && !out_uncorr && (cnt_corr != '1)) cnt_corr <= cnt_corr + CNT_ONE;
            if (out_uncorr && (cnt_uncorr != '1))           cnt_uncorr <= cnt_uncorr + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// Bench for hamming_secded_dec_pipe (R=4): a 16-bit-counter instance and a 2-bit-counter instance
// share one stimulus stream; directed table vectors plus backpressure, reset and saturation sequences.
module tb_hamming_secded_dec_pipe;

    typedef struct {
        logic [15:0] code;
        logic [10:0] data;
        logic        err;
        logic        uncorr;
        logic [3:0]  pos;
    } vec_t;

    localparam int NV = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_code;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready, out_valid, out_err, out_uncorr;
    logic [10:0] out_data;
    logic [15:0] cnt_corr, cnt_uncorr;
    logic        in_ready_s, out_valid_s, out_err_s, out_uncorr_s;
    logic [10:0] out_data_s;
    logic [1:0]  cnt_corr_s, cnt_uncorr_s;
`ifdef HAMMING_DEC_ERRPOS_EN
    logic [3:0]  out_err_pos, out_err_pos_s;
`endif

    always #5 clk = ~clk;

    hamming_secded_dec_pipe #(.R(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .out_uncorr(out_uncorr),
        .cnt_clr(cnt_clr), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
`ifdef HAMMING_DEC_ERRPOS_EN
        , .out_err_pos(out_err_pos)
`endif
    );

    hamming_secded_dec_pipe #(.R(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_code(in_code),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_err(out_err_s), .out_uncorr(out_uncorr_s),
        .cnt_clr(cnt_clr), .cnt_corr(cnt_corr_s), .cnt_uncorr(cnt_uncorr_s)
`ifdef HAMMING_DEC_ERRPOS_EN
        , .out_err_pos(out_err_pos_s)
`endif
    );

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t tbl[NV];
    int   bp_idx[3];
    int   exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int   corr_m, uncorr_m, sent, rcvd;

        //         code      data     err   uncorr pos
        tbl[0] = '{16'h0000, 11'h000, 1'b0, 1'b0, 4'd0};
        tbl[1] = '{16'h0040, 11'h000, 1'b1, 1'b0, 4'd6};
        tbl[2] = '{16'h0014, 11'h003, 1'b1, 1'b1, 4'd0};
        tbl[3] = '{16'h8000, 11'h000, 1'b1, 1'b0, 4'd15};
        tbl[4] = '{16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'd0};
        tbl[5] = '{16'hFDFF, 11'h7FF, 1'b1, 1'b0, 4'd9};
        tbl[6] = '{16'h8007, 11'h001, 1'b0, 1'b0, 4'd0};
        tbl[7] = '{16'h8004, 11'h001, 1'b1, 1'b1, 4'd0};
        tbl[8] = '{16'h8003, 11'h001, 1'b1, 1'b0, 4'd2};
        bp_idx[0] = 4; bp_idx[1] = 5; bp_idx[2] = 7;

        rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_err", 32'(out_err), 32'(0));
        chk("rst_out_uncorr", 32'(out_uncorr), 32'(0));
        chk("rst_cnt_corr", 32'(cnt_corr), 32'(0));
        chk("rst_cnt_uncorr", 32'(cnt_uncorr), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back table stream: result for vector k is valid exactly 2 cycles after it is driven.
        corr_m = 0; uncorr_m = 0;
        for (int c = 0; c < NV + 3; c++) begin
            chk("a_in_ready", 32'(in_ready), 32'(1));
            chk("a_out_valid", 32'(out_valid), 32'(c >= 2 && c < NV + 2));
            chk("a_out_valid_s", 32'(out_valid_s), 32'(c >= 2 && c < NV + 2));
            if (c >= 2 && c < NV + 2) begin
                e = tbl[c-2];
                chk($sformatf("a_data[%0d]", c - 2), 32'(out_data), 32'(e.data));
                chk($sformatf("a_err[%0d]", c - 2), 32'(out_err), 32'(e.err));
                chk($sformatf("a_uncorr[%0d]", c - 2), 32'(out_uncorr), 32'(e.uncorr));
                chk($sformatf("a_data_s[%0d]", c - 2), 32'(out_data_s), 32'(e.data));
                chk($sformatf("a_err_s[%0d]", c - 2), 32'({out_err_s, out_uncorr_s}), 32'({e.err, e.uncorr}));
`ifdef HAMMING_DEC_ERRPOS_EN
                chk($sformatf("a_err_pos[%0d]", c - 2), 32'(out_err_pos), 32'(e.pos));
                chk($sformatf("a_err_pos_s[%0d]", c - 2), 32'(out_err_pos_s), 32'(e.pos));
`endif
            end
            chk("a_cnt_corr", 32'(cnt_corr), 32'(corr_m));
            chk("a_cnt_uncorr", 32'(cnt_uncorr), 32'(uncorr_m));
            chk("a_cnt_corr_s", 32'(cnt_corr_s), 32'(sat3(corr_m)));
            chk("a_cnt_uncorr_s", 32'(cnt_uncorr_s), 32'(sat3(uncorr_m)));
            chk("a_in_ready_s", 32'(in_ready_s), 32'(1));
            if (c >= 2 && c < NV + 2) begin
                if (e.uncorr) uncorr_m++;
                else if (e.err) corr_m++;
            end
            in_valid = (c < NV);
            in_code  = (c < NV) ? tbl[c].code : 16'h0000;
            tick();
        end

        // Backpressure: three words offered while out_ready is low for 5 cycles.
        sent = 0; rcvd = 0;
        for (int c = 0; c < 20 && rcvd < 3; c++) begin
            out_ready = (c >= 5);
            in_valid  = (sent < 3);
            in_code   = (sent < 3) ? tbl[bp_idx[sent]].code : 16'h0000;
            #1;
            if (c >= 2 && c <= 4) chk("b_in_ready_stall", 32'(in_ready), 32'(0));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("b_spurious_valid", 32'(out_valid), 32'(0));
                end else begin
                    e = tbl[exp_q[0]];
                    chk("b_data", 32'(out_data), 32'(e.data));
                    chk("b_flags", 32'({out_err, out_uncorr}), 32'({e.err, e.uncorr}));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        rcvd++;
                        if (e.uncorr) uncorr_m++;
                        else if (e.err) corr_m++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(bp_idx[sent]);
                sent++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("b_received", 32'(rcvd), 32'(3));
        chk("b_cnt_corr", 32'(cnt_corr), 32'(corr_m));
        chk("b_cnt_uncorr", 32'(cnt_uncorr), 32'(uncorr_m));
        chk("b_cnt_corr_s", 32'(cnt_corr_s), 32'(sat3(corr_m)));

        // Reset mid-stream flushes both stages and the counters.
        in_valid = 1'b1; in_code = tbl[4].code;
        tick();
        tick();
        chk("c_pre_rst_valid", 32'(out_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("c_rst_out_valid", 32'(out_valid), 32'(0));
        chk("c_rst_out_data", 32'(out_data), 32'(0));
        chk("c_rst_cnt_corr", 32'(cnt_corr), 32'(0));
        chk("c_rst_cnt_uncorr", 32'(cnt_uncorr), 32'(0));
        chk("c_rst_in_ready", 32'(in_ready), 32'(1));
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("c_flushed_valid", 32'(out_valid), 32'(0));
        end

        // Saturation of the 2-bit counters and clear coincident with an increment.
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                chk("d_cnt_corr_1", 32'(cnt_corr), 32'(1));
                chk("d_cnt_corr_s_1", 32'(cnt_corr_s), 32'(1));
            end
            cnt_clr = 1'b0;
            if (c == 7) begin
                chk("d_valid_at_clr", 32'(out_valid), 32'(1));
                chk("d_cnt_corr_5", 32'(cnt_corr), 32'(5));
                chk("d_cnt_corr_s_sat", 32'(cnt_corr_s), 32'(3));
                cnt_clr = 1'b1;
            end
            if (c >= 8) begin
                chk("d_cnt_corr_clr", 32'(cnt_corr), 32'(0));
                chk("d_cnt_corr_s_clr", 32'(cnt_corr_s), 32'(0));
            end
            in_valid = (c < 6);
            in_code  = tbl[1].code;
            tick();
        end
        cnt_clr = 1'b0;
        chk("d_cnt_uncorr_s", 32'(cnt_uncorr_s), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
